// File: rtl/multi_toggle_gen_pkg.sv
// multi_toggle_gen_pkg
// Shared definitions for the multi-channel toggle generator: the controller
// state type plus the constants and step function of the optional 16-bit
// Galois LFSR (only used when MULTI_TOGGLE_GEN_LFSR_EN is defined).
package multi_toggle_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Right-shifting Galois LFSR: the bit shifted out selects whether the
    // tap mask is folded back into the register.
    function automatic logic [15:0] lfsrNext(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/multi_toggle_gen_toggle_chan.sv
// toggle_chan
// One waveform channel: captures its half-period and starting level when a
// run is loaded, then counts run cycles and flips (or, with
// MULTI_TOGGLE_GEN_LFSR_EN defined and the channel in LFSR mode, reloads
// from the shared LFSR bit) every time the counter reaches H-1.
// A captured half-period of zero freezes the channel at its starting level.
module toggle_chan #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [CNT_W-1:0] i_half,
    input  logic             i_init,
`ifdef MULTI_TOGGLE_GEN_LFSR_EN
    input  logic             i_lfsrSel,
    input  logic             i_lfsrBit,
`endif
    output logic             o_out
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             w_active;
    logic             w_terminal;
    logic             w_nextOut;
`ifdef MULTI_TOGGLE_GEN_LFSR_EN
    logic             r_lfsrSel;
`endif

    assign w_active   = (r_half != '0);
    assign w_terminal = w_active && (r_cnt == (r_half - ONE));

    // Pick the level the channel takes at its terminal count.
    always_comb begin
        w_nextOut = ~r_out;
`ifdef MULTI_TOGGLE_GEN_LFSR_EN
        if (r_lfsrSel) begin
            w_nextOut = i_lfsrBit;
        end
`endif
    end

    // Capture on load, then count and update the output on each run step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_half <= '0;
            r_cnt  <= '0;
            r_out  <= 1'b0;
`ifdef MULTI_TOGGLE_GEN_LFSR_EN
            r_lfsrSel <= 1'b0;
`endif
        end else if (i_load) begin
            r_half <= i_half;
            r_cnt  <= '0;
            r_out  <= i_init;
`ifdef MULTI_TOGGLE_GEN_LFSR_EN
            r_lfsrSel <= i_lfsrSel;
`endif
        end else if (i_step && w_active) begin
            if (w_terminal) begin
                r_cnt <= '0;
                r_out <= w_nextOut;
            end else begin
                r_cnt <= r_cnt + ONE;
            end
        end
    end

    assign o_out = r_out;

endmodule

// File: rtl/multi_toggle_gen.sv
// multi_toggle_gen
// Runs NUM_CH independent square-wave channels for a captured number of
// cycles (or forever when run_len is zero). A start in IDLE loads every
// channel and enters RUN; the run ends normally through a one-cycle DONE
// state that pulses done, or early on abort straight back to IDLE.
// Optional feature: define MULTI_TOGGLE_GEN_LFSR_EN to add the lfsr_mode
// port and a shared 16-bit Galois LFSR that can drive selected channels.
module multi_toggle_gen
    import multi_toggle_gen_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 16,
    parameter int RUN_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [NUM_CH*CNT_W-1:0] half_period,
    input  logic [NUM_CH-1:0]       init_val,
    input  logic [RUN_W-1:0]        run_len,
`ifdef MULTI_TOGGLE_GEN_LFSR_EN
    input  logic [NUM_CH-1:0]       lfsr_mode,
`endif
    output logic [NUM_CH-1:0]       out,
    output logic                    busy,
    output logic                    done
);

    localparam logic [RUN_W-1:0] RUN_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic [RUN_W-1:0]  r_runCnt;
    logic [RUN_W-1:0]  r_runLen;
    logic              r_busy;
    logic              r_done;
    logic              w_load;
    logic              w_step;
    logic              w_last;
    logic [NUM_CH-1:0] w_out;
`ifdef MULTI_TOGGLE_GEN_LFSR_EN
    logic [15:0]       r_lfsr;
`endif

    // A load happens only from IDLE; channels advance on every RUN edge
    // that is not aborted, so an abort leaves the outputs untouched.
    assign w_load = (r_state == IDLE) && start;
    assign w_step = (r_state == RUN) && !abort;
    assign w_last = (r_runLen != '0) && (r_runCnt == (r_runLen - RUN_ONE));

    // Controller FSM with registered busy/done and the run-length counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_runCnt <= '0;
            r_runLen <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef MULTI_TOGGLE_GEN_LFSR_EN
            r_lfsr   <= LFSR_SEED;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_runLen <= run_len;
                        r_runCnt <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
`ifdef MULTI_TOGGLE_GEN_LFSR_EN
                        r_lfsr   <= LFSR_SEED;
`endif
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_runCnt <= r_runCnt + RUN_ONE;
`ifdef MULTI_TOGGLE_GEN_LFSR_EN
                        r_lfsr   <= lfsrNext(r_lfsr);
`endif
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // One counter/toggle slice per channel.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        toggle_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .i_load    (w_load),
            .i_step    (w_step),
            .i_half    (half_period[gi*CNT_W +: CNT_W]),
            .i_init    (init_val[gi]),
`ifdef MULTI_TOGGLE_GEN_LFSR_EN
            .i_lfsrSel (lfsr_mode[gi]),
            .i_lfsrBit (r_lfsr[gi % 16]),
`endif
            .o_out     (w_out[gi])
        );
    end

    assign out  = w_out;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_multi_toggle_gen.sv
// tb_multi_toggle_gen
// Self-checking bench for multi_toggle_gen (NUM_CH=3). Expected outputs come
// from hand-written vector tables and from a run-level reference model that
// derives each channel level from the number of run cycles elapsed.
// Define MULTI_TOGGLE_GEN_LFSR_EN to also exercise the LFSR channel mode.
module tb_multi_toggle_gen;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;
    localparam int RUN_W  = 16;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic                    abort;
    logic [NUM_CH*CNT_W-1:0] halfPeriod;
    logic [NUM_CH-1:0]       initVal;
    logic [RUN_W-1:0]        runLen;
    logic [NUM_CH-1:0]       out;
    logic                    busy;
    logic                    done;
`ifdef MULTI_TOGGLE_GEN_LFSR_EN
    logic [NUM_CH-1:0]       lfsrMode;
`endif

    always #5 clk = ~clk;

    multi_toggle_gen #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .RUN_W (RUN_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .half_period (halfPeriod),
        .init_val    (initVal),
        .run_len     (runLen),
`ifdef MULTI_TOGGLE_GEN_LFSR_EN
        .lfsr_mode   (lfsrMode),
`endif
        .out         (out),
        .busy        (busy),
        .done        (done)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: phase 0=idle, 1=running, 2=finished (one cycle).
    int                mPhase = 0;
    int                mK = 0;
    int                mH [NUM_CH];
    logic [NUM_CH-1:0] mInit = '0;
    logic [NUM_CH-1:0] mOut = '0;
    int                mLen = 0;
    logic [15:0]       mLfsr = 16'hACE1;
    logic [NUM_CH-1:0] mMode = '0;

    // Run tallies for the long hand-written runs.
    int                toggles [NUM_CH];
    int                busyCycles;
    int                donePulses;
    logic [NUM_CH-1:0] prevOut;

    typedef struct {
        logic              rst;
        logic              st;
        logic              ab;
        logic [NUM_CH-1:0] eOut;
        logic              eBusy;
        logic              eDone;
    } vec_t;

    vec_t vecs [12];

    // Advance the model by one clock edge given the inputs sampled there.
    task automatic modelEdge(input logic r, input logic s, input logic a);
        logic [15:0] lf;
        if (r) begin
            mPhase = 0;
            mOut   = '0;
        end else if (mPhase == 0) begin
            if (s) begin
                for (int i = 0; i < NUM_CH; i++) mH[i] = int'(halfPeriod[i*CNT_W +: CNT_W]);
                mInit  = initVal;
                mOut   = initVal;
                mLen   = int'(runLen);
                mK     = 0;
                mLfsr  = 16'hACE1;
`ifdef MULTI_TOGGLE_GEN_LFSR_EN
                mMode  = lfsrMode;
`else
                mMode  = '0;
`endif
                mPhase = 1;
            end
        end else if (mPhase == 1) begin
            if (a) begin
                mPhase = 0;
            end else begin
                mK = mK + 1;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (mH[i] != 0) begin
                        if (mMode[i]) begin
                            if (mK % mH[i] == 0) mOut[i] = mLfsr[i % 16];
                        end else begin
                            mOut[i] = mInit[i] ^ (((mK / mH[i]) % 2) != 0);
                        end
                    end
                end
                lf    = mLfsr;
                mLfsr = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
                if (mLen != 0 && mK == mLen) mPhase = 2;
            end
        end else begin
            mPhase = 0;
        end
    endtask

    // Drive control inputs for one edge, update the model, settle past the edge.
    task automatic applyStimulus(input logic r, input logic s, input logic a);
        reset = r;
        start = s;
        abort = a;
        @(posedge clk);
        modelEdge(r, s, a);
        #1;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic checkOutput(input logic [NUM_CH-1:0] eOut, input logic eBusy,
                               input logic eDone, input string name);
        testsRun++;
        if (out !== eOut) begin
            testsFailed++;
            $display("[TB] FAIL %s out: got %b expected %b", name, out, eOut);
        end
        testsRun++;
        if (busy !== eBusy) begin
            testsFailed++;
            $display("[TB] FAIL %s busy: got %b expected %b", name, busy, eBusy);
        end
        testsRun++;
        if (done !== eDone) begin
            testsFailed++;
            $display("[TB] FAIL %s done: got %b expected %b", name, done, eDone);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        testsRun++;
        if (got != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic clearTally();
        for (int i = 0; i < NUM_CH; i++) toggles[i] = 0;
        busyCycles = busy ? 1 : 0;
        donePulses = 0;
        prevOut    = out;
    endtask

    // Idle-input edges, each checked against the model and tallied.
    task automatic runEdges(input int n, input string name);
        for (int c = 0; c < n; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput(mOut, mPhase == 1, mPhase == 2, name);
            for (int i = 0; i < NUM_CH; i++) if (out[i] !== prevOut[i]) toggles[i]++;
            prevOut = out;
            if (busy) busyCycles++;
            if (done) donePulses++;
        end
    endtask

    task automatic setMainParams();
        halfPeriod = {16'd75, 16'd55, 16'd10};
        initVal    = 3'b000;
        runLen     = 16'd300;
    endtask

    // Full 300-cycle run with three different half-periods.
    task automatic mainRun(input string name);
        setMainParams();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput(3'b000, 1'b1, 1'b0, {name, "_load"});
        clearTally();
        runEdges(300, name);
        checkValue({name, "_done_at_end"}, int'(done), 1);
        runEdges(1, name);
        checkValue({name, "_tog0"}, toggles[0], 30);
        checkValue({name, "_tog1"}, toggles[1], 5);
        checkValue({name, "_tog2"}, toggles[2], 4);
        checkValue({name, "_busy_cycles"}, busyCycles, 300);
        checkValue({name, "_done_pulses"}, donePulses, 1);
        checkOutput(3'b010, 1'b0, 1'b0, {name, "_final"});
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        halfPeriod = '0;
        initVal    = '0;
        runLen     = '0;
`ifdef MULTI_TOGGLE_GEN_LFSR_EN
        lfsrMode   = '0;
`endif
        for (int i = 0; i < NUM_CH; i++) mH[i] = 0;

        // Short run H={4,0,1}, init=010, len=8, then an ignored abort in idle.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 3'b110, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 3'b110, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 3'b011, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 3'b011, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0};

        halfPeriod = {16'd1, 16'd0, 16'd4};
        initVal    = 3'b010;
        runLen     = 16'd8;
        for (int v = 0; v < 12; v++) begin
            applyStimulus(vecs[v].rst, vecs[v].st, vecs[v].ab);
            checkOutput(vecs[v].eOut, vecs[v].eBusy, vecs[v].eDone, $sformatf("vec%0d", v));
        end

        // Main 300-cycle run.
        mainRun("main");

        // Abort on the 20th run edge: outputs freeze at the 19-edge value.
        setMainParams();
        applyStimulus(1'b0, 1'b1, 1'b0);
        clearTally();
        runEdges(19, "abort_pre");
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput(3'b001, 1'b0, 1'b0, "abort_edge");
        clearTally();
        runEdges(3, "abort_post");
        checkValue("abort_no_done", donePulses, 0);
        checkOutput(3'b001, 1'b0, 1'b0, "abort_frozen");

        // Unbounded run past the run-counter wrap, ended by abort.
        halfPeriod = {16'd0, 16'd0, 16'd3};
        initVal    = 3'b100;
        runLen     = 16'd0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        clearTally();
        runEdges(70000, "unbounded");
        checkValue("unbounded_busy", busyCycles, 70001);
        checkValue("unbounded_done", donePulses, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput(mOut, 1'b0, 1'b0, "unbounded_abort");

        // Reset together with start in the middle of a run, then a fresh run.
        setMainParams();
        applyStimulus(1'b0, 1'b1, 1'b0);
        clearTally();
        runEdges(50, "pre_reset");
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput(3'b000, 1'b0, 1'b0, "reset_mid_run");
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput(3'b000, 1'b0, 1'b0, "reset_settled");
        mainRun("after_reset");

`ifdef MULTI_TOGGLE_GEN_LFSR_EN
        // Channel 0 in LFSR mode with H=1 follows the LFSR bit every edge.
        lfsrMode   = 3'b001;
        halfPeriod = {16'd0, 16'd0, 16'd1};
        initVal    = 3'b000;
        runLen     = 16'd100;
        applyStimulus(1'b0, 1'b1, 1'b0);
        clearTally();
        runEdges(101, "lfsr");
        lfsrMode   = 3'b000;
`endif

        // Randomised control traffic with mid-run parameter changes.
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 60; c++) begin
                logic rr;
                logic ss;
                logic aa;
                if ($urandom_range(0, 7) == 0) begin
                    for (int i = 0; i < NUM_CH; i++)
                        halfPeriod[i*CNT_W +: CNT_W] = 16'($urandom_range(0, 9));
                    initVal = 3'($urandom_range(0, 7));
                    runLen  = 16'($urandom_range(0, 40));
`ifdef MULTI_TOGGLE_GEN_LFSR_EN
                    lfsrMode = 3'($urandom_range(0, 7));
`endif
                end
                rr = ($urandom_range(0, 63) == 0);
                ss = ($urandom_range(0, 3) == 0);
                aa = ($urandom_range(0, 15) == 0);
                applyStimulus(rr, ss, aa);
                checkOutput(mOut, mPhase == 1, mPhase == 2, $sformatf("rand%0d_%0d", r, c));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
